// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC fetch sequencer: state encodings, PC step and default vectors.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_UPDATE = 2'd3
    } pc_state_t;

    localparam logic [31:0] PC_INCR          = 32'h0000_0004;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: jump over branch over sequential +4.
// PC_FETCH_CTRL_ALIGN_CHECK_EN redirects misaligned targets to TRAP_VECTOR.
module pc_next_sel
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
    input  logic [31:0] pc_cur,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_sel,
    output logic        misaligned
);

    logic [31:0] target;

    always_comb begin
        target = pc_cur + PC_INCR;
        if (jump) begin
            target = jump_target;
        end else if (branch_taken) begin
            target = branch_target;
        end
    end

`ifdef PC_FETCH_CTRL_ALIGN_CHECK_EN
    assign misaligned = |target[1:0];
    assign pc_sel     = misaligned ? TRAP_VECTOR : target;
`else
    logic unused_trap;
    assign unused_trap = ^TRAP_VECTOR;
    assign misaligned  = 1'b0;
    assign pc_sel      = target;
`endif

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Sequencer for the Save_PC register: BOOT -> FETCH -> EXEC -> UPDATE.
// Optional alignment trap enabled by PC_FETCH_CTRL_ALIGN_CHECK_EN.
//
// state  | meaning
// BOOT   | drive RESET_VECTOR into Save_PC
// FETCH  | request instruction at PC_Cur, wait for IMem_Ready
// EXEC   | count down EXEC_CYCLES execution cycles
// UPDATE | write selected next PC and retire the instruction
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter int unsigned EXEC_CYCLES  = 2,
    parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC_Cur,
    input  logic        IMem_Ready,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Jump,
    input  logic [31:0] Jump_Target,
    output logic [31:0] PC_Next,
    output logic        PC_We,
    output logic        IMem_Req,
    output logic        Instr_Valid,
    output logic [31:0] Retired,
    output logic [1:0]  State,
    output logic        Misaligned
);

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES);

    pc_state_t   state_q, state_d;
    logic [3:0]  exec_cnt_q;
    logic        fetch_done;
    logic        retire;
    logic [31:0] pc_sel;
    logic        sel_misaligned;
    logic        instr_valid_q;
    logic        misaligned_q;
    logic [31:0] retired_q;

    pc_next_sel #(
        .TRAP_VECTOR(TRAP_VECTOR)
    ) u_next_sel (
        .pc_cur       (PC_Cur),
        .branch_taken (Branch_Taken),
        .branch_target(Branch_Target),
        .jump         (Jump),
        .jump_target  (Jump_Target),
        .pc_sel       (pc_sel),
        .misaligned   (sel_misaligned)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_FETCH;
            ST_FETCH:  if (fetch_done) state_d = (EXEC_LOAD == 4'd0) ? ST_UPDATE : ST_EXEC;
            ST_EXEC:   if (!Stall && exec_cnt_q <= 4'd1) state_d = ST_UPDATE;
            ST_UPDATE: if (!Stall) state_d = ST_FETCH;
            default:   state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        fetch_done = (state_q == ST_FETCH) && IMem_Ready && !Stall;
        retire     = (state_q == ST_UPDATE) && !Stall;
        IMem_Req   = (state_q == ST_FETCH);
        PC_Next    = PC_Cur;
        PC_We      = 1'b0;
        if (state_q == ST_BOOT) begin
            PC_Next = RESET_VECTOR;
            PC_We   = 1'b1;
        end else if (retire) begin
            PC_Next = pc_sel;
            PC_We   = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            exec_cnt_q <= 4'd0;
        end else if (fetch_done) begin
            exec_cnt_q <= EXEC_LOAD;
        end else if (state_q == ST_EXEC && !Stall && exec_cnt_q != 4'd0) begin
            exec_cnt_q <= exec_cnt_q - 4'd1;
        end
    end

    // Retire flags are registered so they line up with the new PC_Cur
    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            retired_q     <= 32'd0;
        end else begin
            instr_valid_q <= retire;
            misaligned_q  <= retire & sel_misaligned;
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign Instr_Valid = instr_valid_q;
    assign Misaligned  = misaligned_q;
    assign Retired     = retired_q;
    assign State       = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a Save_PC register model in the loop.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc_cur;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc_next;
    logic        pc_we;
    logic        imem_req;
    logic        instr_valid;
    logic [31:0] retired;
    logic [1:0]  state;
    logic        misaligned;

    int checks;
    int failures;

`ifdef PC_FETCH_CTRL_ALIGN_CHECK_EN
    localparam logic [31:0] EXP_ODD_PC  = 32'h0000_0100;
    localparam logic        EXP_ODD_MIS = 1'b1;
`else
    localparam logic [31:0] EXP_ODD_PC  = 32'h0000_0042;
    localparam logic        EXP_ODD_MIS = 1'b0;
`endif

    pc_fetch_ctrl dut (
        .CLK          (clk),
        .RST          (rst),
        .PC_Cur       (pc_cur),
        .IMem_Ready   (imem_ready),
        .Stall        (stall),
        .Branch_Taken (branch_taken),
        .Branch_Target(branch_target),
        .Jump         (jump),
        .Jump_Target  (jump_target),
        .PC_Next      (pc_next),
        .PC_We        (pc_we),
        .IMem_Req     (imem_req),
        .Instr_Valid  (instr_valid),
        .Retired      (retired),
        .State        (state),
        .Misaligned   (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Save_PC: plain register with no enable
    initial pc_cur = 32'hDEAD_BEEF;
    always @(posedge clk) pc_cur <= pc_next;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Starts at a FETCH negedge with IMem_Ready high; ends at the next FETCH negedge
    task automatic run_instr(input logic [31:0] exp_pc, input logic [31:0] exp_ret, input logic exp_mis);
        step();
        check_eq("exec1_state", 32'(state), 32'd2);
        step();
        check_eq("exec2_state", 32'(state), 32'd2);
        step();
        check_eq("upd_state", 32'(state), 32'd3);
        check_eq("upd_we", 32'(pc_we), 32'd1);
        check_eq("upd_next", pc_next, exp_pc);
        check_eq("upd_valid", 32'(instr_valid), 32'd0);
        step();
        check_eq("fetch_state", 32'(state), 32'd1);
        check_eq("fetch_pc", pc_cur, exp_pc);
        check_eq("fetch_valid", 32'(instr_valid), 32'd1);
        check_eq("fetch_retired", retired, exp_ret);
        check_eq("fetch_misaligned", 32'(misaligned), 32'(exp_mis));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        imem_ready    = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;

        step();
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_retired", retired, 32'd0);
        check_eq("boot_we", 32'(pc_we), 32'd1);
        check_eq("boot_next", pc_next, 32'h0);
        rst = 1'b0;
        step();
        check_eq("first_fetch_state", 32'(state), 32'd1);
        check_eq("first_fetch_pc", pc_cur, 32'h0);
        check_eq("first_fetch_req", 32'(imem_req), 32'd1);
        check_eq("first_fetch_we", 32'(pc_we), 32'd0);

        run_instr(32'h4, 32'd1, 1'b0);
        run_instr(32'h8, 32'd2, 1'b0);
        run_instr(32'hC, 32'd3, 1'b0);

        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("wait_state", 32'(state), 32'd1);
            check_eq("wait_req", 32'(imem_req), 32'd1);
            check_eq("wait_pc", pc_cur, 32'hC);
        end
        imem_ready = 1'b1;
        run_instr(32'h10, 32'd4, 1'b0);

        branch_taken  = 1'b1;
        branch_target = 32'h40;
        jump          = 1'b1;
        jump_target   = 32'h80;
        run_instr(32'h80, 32'd5, 1'b0);
        jump = 1'b0;
        run_instr(32'h40, 32'd6, 1'b0);
        branch_taken = 1'b0;

        step();
        check_eq("stall_enter_exec", 32'(state), 32'd2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_exec_state", 32'(state), 32'd2);
            check_eq("stall_exec_pc", pc_cur, 32'h40);
            check_eq("stall_exec_valid", 32'(instr_valid), 32'd0);
        end
        stall = 1'b0;
        step();
        check_eq("resume_exec_state", 32'(state), 32'd2);
        step();
        check_eq("resume_upd_state", 32'(state), 32'd3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_upd_state", 32'(state), 32'd3);
            check_eq("stall_upd_we", 32'(pc_we), 32'd0);
            check_eq("stall_upd_next", pc_next, 32'h40);
            check_eq("stall_upd_valid", 32'(instr_valid), 32'd0);
            check_eq("stall_upd_retired", retired, 32'd6);
        end
        stall = 1'b0;
        step();
        check_eq("stall_done_pc", pc_cur, 32'h44);
        check_eq("stall_done_valid", 32'(instr_valid), 32'd1);
        check_eq("stall_done_retired", retired, 32'd7);

        step();
        check_eq("pre_rst_exec", 32'(state), 32'd2);
        rst = 1'b1;
        step();
        check_eq("abort_state", 32'(state), 32'd0);
        check_eq("abort_retired", retired, 32'd0);
        check_eq("abort_valid", 32'(instr_valid), 32'd0);
        check_eq("abort_pc_held", pc_cur, 32'h44);
        rst = 1'b0;
        step();
        check_eq("reboot_state", 32'(state), 32'd1);
        check_eq("reboot_pc", pc_cur, 32'h0);

        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        run_instr(32'hFFFF_FFFC, 32'd1, 1'b0);
        jump = 1'b0;
        run_instr(32'h0, 32'd2, 1'b0);

        jump        = 1'b1;
        jump_target = 32'h42;
        run_instr(EXP_ODD_PC, 32'd3, EXP_ODD_MIS);
        jump = 1'b0;
        step();
        check_eq("mis_pulse_end", 32'(misaligned), 32'd0);
        check_eq("valid_pulse_end", 32'(instr_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequencing controller for the program-counter register (Save_PC) in the multicycle RISC-V core.
- Runs the BOOT → FETCH → EXEC → UPDATE state machine.
- Handshakes with instruction memory.
- Selects the next PC: sequential, branch or jump.
- Drives Save_PC's PC_In so the PC changes only in the UPDATE cycle. Save_PC has no enable, so the block feeds back PC_Cur in every other cycle.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded after reset.
- EXEC_CYCLES, 2, number of EXEC-state cycles per instruction (0..15; 0 skips EXEC).
- TRAP_VECTOR, 32'h0000_0100, redirect target on misaligned target (optional feature only).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset; one clock, synchronous, active-high.
- PC_Cur  in  32  current PC from Save_PC PC_Out.
- IMem_Ready  in  1  instruction memory has returned the word for PC_Cur.
- Stall  in  1  freeze request from the datapath.
- Branch_Taken  in  1  branch condition true; sampled in UPDATE.
- Branch_Target  in  32  branch destination.
- Jump  in  1  JAL/JALR; sampled in UPDATE.
- Jump_Target  in  32  jump destination.
- PC_Next  out  32  to Save_PC PC_In.
- PC_We  out  1  high when PC_Next differs from hold value (BOOT, UPDATE).
- IMem_Req  out  1  fetch request for address PC_Cur.
- Instr_Valid  out  1  one-cycle pulse when an instruction retires.
- Retired  out  32  count of retired instructions.
- State  out  2  BOOT=0, FETCH=1, EXEC=2, UPDATE=3.
- Misaligned  out  1  optional feature only; tied 0 otherwise.

Behaviour:
- Reset (RST high at an edge):
  - State = BOOT, exec counter = 0, Retired = 0.
  - IMem_Req = 0, Instr_Valid = 0.
  - Reset mid-operation aborts immediately; the PC is not written by the aborted instruction.
- PC_Next and PC_We are combinational from State; all other outputs are registered or decoded from State.
- BOOT:
  - PC_Next = RESET_VECTOR, PC_We = 1.
  - Unconditionally → FETCH next cycle, so PC_Cur = RESET_VECTOR in the first FETCH cycle.
- FETCH:
  - IMem_Req = 1, PC_Next = PC_Cur, PC_We = 0.
  - If IMem_Ready & !Stall: → EXEC and load exec counter = EXEC_CYCLES. If EXEC_CYCLES = 0, go → UPDATE instead.
  - Otherwise stay in FETCH; IMem_Req is held high.
- EXEC:
  - PC_Next = PC_Cur, PC_We = 0.
  - Counter decrements when !Stall.
  - When counter = 1 & !Stall: → UPDATE.
  - Minimum EXEC residency is exactly EXEC_CYCLES cycles.
- UPDATE (if !Stall):
  - PC_We = 1, Instr_Valid = 1 on the following cycle (registered pulse), Retired increments, → FETCH.
  - PC_Next priority: Jump → Jump_Target; else Branch_Taken → Branch_Target; else PC_Cur + 32'h4.
  - Addition is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0.
- UPDATE with Stall: stay in UPDATE, PC_Next = PC_Cur, PC_We = 0, no retire.
- Stall has no effect in BOOT.
- Jump and Branch_Taken both high: Jump wins.
- Retired wraps 32'hFFFF_FFFF → 0.
- Instruction latency with no stalls: 1 (FETCH, if Ready immediately) + EXEC_CYCLES + 1 (UPDATE) cycles.

Optional Feature:
- Macro: PC_FETCH_CTRL_ALIGN_CHECK_EN.
- Defined: in UPDATE, if the selected target has bits [1:0] != 0:
  - PC_Next = TRAP_VECTOR instead.
  - Misaligned pulses high for one cycle, registered together with Instr_Valid.
  - Retired still increments.
- Undefined: targets pass unmodified and Misaligned is tied 0.

Decomposition:
- Shared package pc_ctrl_pkg holds:
  - State encodings (BOOT/FETCH/EXEC/UPDATE).
  - PC increment constant 32'h4.
  - Default RESET_VECTOR and TRAP_VECTOR.
- One natural sub-module, pc_next_sel: purely combinational priority mux plus +4 adder plus optional alignment check. The FSM, counter and retire logic stay in the top level.

Test Plan:
- RST high 1 cycle then low, IMem_Ready = 1, no branch/jump, EXEC_CYCLES = 2 → PC_Cur sequence 0, 4, 8, 0xC; one update every 4 cycles; Retired = 3 after the third Instr_Valid.
- IMem_Ready low for 5 cycles in FETCH → IMem_Req stays 1, PC_Cur held, State = 1 throughout; advance on the first Ready cycle.
- UPDATE with Branch_Taken = 1, Branch_Target = 0x40, Jump = 1, Jump_Target = 0x80 → PC_Cur = 0x80; repeat with Jump = 0 → 0x40.
- Stall = 1 for 3 cycles in EXEC and in UPDATE → counter and PC frozen, no Instr_Valid; resumes exactly where it stopped.
- RST asserted in EXEC with PC_Cur = 0x8 → next cycle State = BOOT, then PC_Cur = RESET_VECTOR, Retired = 0; PC_Cur = 0xFFFF_FFFC sequential → 0x0.
- With PC_FETCH_CTRL_ALIGN_CHECK_EN, Jump_Target = 0x42 → PC_Cur = TRAP_VECTOR (0x100), Misaligned one-cycle pulse.
